// File: rtl/line_fifo_pkg.sv
// rtl/line_fifo_pkg.sv - shared constants and word type for the 1k x 32 line FIFO
package line_fifo_pkg;

  localparam int FIFO_DATA_WIDTH = 32;
  localparam int FIFO_DEPTH      = 1024;
  localparam int FIFO_ADDR_WIDTH = 10;

  typedef logic [31:0] fifo_word_t;

endpackage

// File: rtl/fifo_sdp_ram.sv
// rtl/fifo_sdp_ram.sv - simple dual-port RAM, registered read-first read port, no reset
module fifo_sdp_ram
  import line_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
  parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH
) (
  input  logic                  clock,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Write and read share one process so a same-address access returns the old word
  // (needed when the FIFO is full and pushes into the slot being popped).
  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/line_fifo_1kx32.sv
// rtl/line_fifo_1kx32.sv - single-clock 1k x 32 line FIFO; FIFO_SHOWAHEAD_EN selects show-ahead q
module line_fifo_1kx32
  import line_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
  parameter int DEPTH      = FIFO_DEPTH,
  parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  sclr,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  wrreq,
  input  logic                  rdreq,
  output logic [DATA_WIDTH-1:0] q,
  output logic                  empty,
  output logic                  full,
  output logic [ADDR_WIDTH:0]   usedw
);

  localparam logic [ADDR_WIDTH-1:0] PTR_ONE    = 1;
  localparam logic [ADDR_WIDTH:0]   CNT_ONE    = 1;
  localparam logic [ADDR_WIDTH:0]   FULL_COUNT = (ADDR_WIDTH+1)'(DEPTH);

  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [ADDR_WIDTH:0]   count;
  logic                  wr_acc;
  logic                  rd_acc;
  logic                  ram_rd_en;
  logic                  q_zero;
  logic [DATA_WIDTH-1:0] ram_q;

  assign usedw = count;
  assign empty = (count == '0);
  assign full  = (count == FULL_COUNT);

  // Accept decisions: a full FIFO still takes a write when the same cycle pops; sclr drops both.
  always_comb begin
    wr_acc = 1'b0;
    rd_acc = 1'b0;
    if (!sclr) begin
      wr_acc = wrreq && (!full || rdreq);
      rd_acc = rdreq && !empty;
    end
  end

`ifdef FIFO_SHOWAHEAD_EN
  logic                  byp_sel;
  logic [DATA_WIDTH-1:0] byp_data;

  // Show-ahead: RAM always fetches the word that will be the head after this edge.
  always_comb begin
    ram_rd_en = 1'b1;
    rd_addr   = rd_ptr;
    if (sclr)        rd_addr = '0;
    else if (rd_acc) rd_addr = rd_ptr + PTR_ONE;
  end

  // Bypass the word being written when it becomes the head on the same edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      byp_sel  <= 1'b0;
      byp_data <= '0;
    end else begin
      byp_sel <= wr_acc && (wr_ptr == rd_addr);
      if (wr_acc && (wr_ptr == rd_addr)) byp_data <= data;
    end
  end

  // q is forced to zero after reset/clear until the first word arrives.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)       q_zero <= 1'b1;
    else if (sclr)   q_zero <= 1'b1;
    else if (wr_acc) q_zero <= 1'b0;
  end

  assign q = q_zero ? '0 : (byp_sel ? byp_data : ram_q);
`else
  // Normal mode: the RAM output register only loads on an accepted read, so q holds otherwise.
  always_comb begin
    ram_rd_en = rd_acc;
    rd_addr   = rd_ptr;
  end

  // The RAM has no reset, so q is masked to zero until the first read after reset/clear.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)       q_zero <= 1'b1;
    else if (sclr)   q_zero <= 1'b1;
    else if (rd_acc) q_zero <= 1'b0;
  end

  assign q = q_zero ? '0 : ram_q;
`endif

  // Pointers and occupancy; occupancy alone drives empty/full.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (sclr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + PTR_ONE;
      if (rd_acc) rd_ptr <= rd_ptr + PTR_ONE;
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  fifo_sdp_ram #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_ram (
    .clock  (clock),
    .wr_en  (wr_acc),
    .wr_addr(wr_ptr),
    .wr_data(data),
    .rd_en  (ram_rd_en),
    .rd_addr(rd_addr),
    .rd_data(ram_q)
  );

endmodule

// File: tb/tb_line_fifo_1kx32.sv
// tb/tb_line_fifo_1kx32.sv - scoreboard bench for line_fifo_1kx32 (normal mode)
module tb_line_fifo_1kx32;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        sclr  = 1'b0;
  logic        wrreq = 1'b0;
  logic        rdreq = 1'b0;
  logic [31:0] data  = '0;
  logic [31:0] q;
  logic        empty;
  logic        full;
  logic [10:0] usedw;

  int          checks   = 0;
  int          failures = 0;
  logic [31:0] exp_q[$];
  logic        rd_exp = 1'b0;

  always #5 clock = ~clock;

  line_fifo_1kx32 dut (
    .clock(clock),
    .reset(reset),
    .sclr (sclr),
    .data (data),
    .wrreq(wrreq),
    .rdreq(rdreq),
    .q    (q),
    .empty(empty),
    .full (full),
    .usedw(usedw)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // One clock of stimulus; rexp says whether this rdreq must pop, qexp is the word it returns.
  task automatic cyc(input logic w, input logic [31:0] d, input logic r,
                     input logic rexp, input logic [31:0] qexp, input logic s);
    wrreq  = w;
    data   = d;
    rdreq  = r;
    sclr   = s;
    rd_exp = rexp;
    if (rexp) exp_q.push_back(qexp);
    @(posedge clock);
    #1;
    wrreq  = 1'b0;
    rdreq  = 1'b0;
    sclr   = 1'b0;
    rd_exp = 1'b0;
  endtask

  task automatic wr(input logic [31:0] d);
    cyc(1'b1, d, 1'b0, 1'b0, '0, 1'b0);
  endtask

  task automatic rd(input logic [31:0] e);
    cyc(1'b0, '0, 1'b1, 1'b1, e, 1'b0);
  endtask

  task automatic idle();
    cyc(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
  endtask

  // Monitor: after each edge on which a pop was expected, compare q against the queue head.
  initial begin : monitor
    logic        fire;
    logic [31:0] e;
    forever begin
      @(posedge clock);
      fire = rd_exp;
      @(negedge clock);
      if (fire) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL q_underflow: got 0x%08h expected no pop", q);
        end else begin
          e = exp_q.pop_front();
          chk("q_data", q, e);
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;

    // Reset state and rdreq on empty
    chk("rst_empty", {31'b0, empty}, 1);
    chk("rst_full", {31'b0, full}, 0);
    chk("rst_usedw", {21'b0, usedw}, 0);
    chk("rst_q", q, 0);
    cyc(1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
    chk("rd_empty_q", q, 0);
    chk("rd_empty_usedw", {21'b0, usedw}, 0);

    // Five words in, five out
    for (int i = 1; i <= 5; i++) wr(i);
    chk("five_usedw", {21'b0, usedw}, 5);
    for (int i = 1; i <= 5; i++) rd(i);
    chk("five_empty", {31'b0, empty}, 1);

    // Fill to 1024 (write pointer wraps), ignored overflow, push+pop while full
    for (int i = 0; i < 1024; i++) wr(i);
    chk("fill_full", {31'b0, full}, 1);
    chk("fill_usedw", {21'b0, usedw}, 1024);
    wr(32'hDEAD_BEEF);
    chk("ovf_usedw", {21'b0, usedw}, 1024);
    cyc(1'b1, 32'hCAFE_0000, 1'b1, 1'b1, 32'h0000_0000, 1'b0);
    chk("full_rw_usedw", {21'b0, usedw}, 1024);
    chk("full_rw_full", {31'b0, full}, 1);
    for (int i = 1; i < 1024; i++) rd(i);
    rd(32'hCAFE_0000);
    chk("drain_empty", {31'b0, empty}, 1);
    idle();

    // Push+pop while empty: write only, q holds
    cyc(1'b1, 32'h0000_55AA, 1'b1, 1'b0, '0, 1'b0);
    chk("empty_rw_usedw", {21'b0, usedw}, 1);
    chk("empty_rw_q", q, 32'hCAFE_0000);
    rd(32'h0000_55AA);
    chk("empty_rw_drain", {31'b0, empty}, 1);

    // One-line delay: 702 stored, then push+pop every cycle
    for (int k = 0; k < 702; k++) wr(32'h1000_0000 + k);
    chk("line_usedw0", {21'b0, usedw}, 702);
    for (int j = 0; j < 2000; j++) begin
      cyc(1'b1, 32'h1000_0000 + 702 + j, 1'b1, 1'b1, 32'h1000_0000 + j, 1'b0);
      chk("line_usedw", {21'b0, usedw}, 702);
    end

    // Drain to 300 stored, then sclr with a concurrent write
    for (int k = 0; k < 402; k++) rd(32'h1000_0000 + 2000 + k);
    chk("pre_sclr_usedw", {21'b0, usedw}, 300);
    cyc(1'b1, 32'h7777_7777, 1'b0, 1'b0, '0, 1'b1);
    chk("sclr_usedw", {21'b0, usedw}, 0);
    chk("sclr_empty", {31'b0, empty}, 1);
    chk("sclr_q", q, 0);
    cyc(1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
    chk("sclr_rd_q", q, 0);
    chk("sclr_rd_usedw", {21'b0, usedw}, 0);

    // Asynchronous reset mid-stream, checked before any further clock edge
    wr(32'hA000_0001);
    wr(32'hA000_0002);
    wr(32'hA000_0003);
    rd(32'hA000_0001);
    idle();
    chk("pre_rst_usedw", {21'b0, usedw}, 2);
    #2 reset = 1'b1;
    #1;
    chk("arst_usedw", {21'b0, usedw}, 0);
    chk("arst_empty", {31'b0, empty}, 1);
    chk("arst_full", {31'b0, full}, 0);
    chk("arst_q", q, 0);
    #1 reset = 1'b0;
    @(posedge clock);
    #1;
    wr(32'hB000_0000);
    rd(32'hB000_0000);
    idle();
    idle();
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
